// File: rtl/serial_to_parallel_stream.sv
// rtl/serial_to_parallel_stream.sv - packs in_width-bit serial beats into out_width-bit words
// Valid/ready on both sides; flush emits a partial word with its beat count.
module serial_to_parallel_stream #(
    parameter int in_width  = 1,
    parameter int out_width = 8,
    parameter bit msb_first = 1'b0,
    localparam int beats    = out_width / in_width,
    localparam int cw       = $clog2(beats + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_valid,
    output logic                 serial_ready,
    input  logic [in_width-1:0]  serial_data,
    input  logic                 flush,
    output logic                 parallel_valid,
    input  logic                 parallel_ready,
    output logic [out_width-1:0] parallel_data,
    output logic [cw-1:0]        parallel_count
);

    localparam logic [cw-1:0] beats_c = cw'(beats);

    if ((out_width % in_width) != 0 || beats < 2) begin : g_param_check
        $error("serial_to_parallel_stream: out_width must be a multiple (>=2) of in_width");
    end

    logic [out_width-1:0] acc;
    logic [cw-1:0]        acc_count;
    logic                 flush_pending;

    logic                 out_free;
    logic                 full;
    logic                 accept;
    logic                 complete;
    logic                 emit_req;
    logic [cw-1:0]        k;
    logic [cw-1:0]        lane;
    logic [out_width-1:0] beat_word;
    logic [out_width-1:0] nacc;
    logic [cw-1:0]        ncount;

    // A full acc unloads when the output frees up, so a new beat can start the next word in that same cycle.
    always_comb begin
        out_free     = !parallel_valid || parallel_ready;
        full         = (acc_count == beats_c);
        serial_ready = !flush_pending && (!full || out_free);
        accept       = serial_valid && serial_ready;
        k            = full ? '0 : acc_count;
        lane         = msb_first ? (beats_c - cw'(1) - k) : k;
        beat_word    = '0;
        for (int j = 0; j < beats; j++) begin
            if (lane == cw'(j)) begin
                beat_word[j*in_width +: in_width] = serial_data;
            end
        end
        nacc     = (full ? '0 : acc) | (accept ? beat_word : '0);
        ncount   = (full ? '0 : acc_count) + cw'(accept);
        complete = !full && accept && (ncount == beats_c);
        emit_req = complete || ((flush || flush_pending) && (ncount != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc            <= '0;
            acc_count      <= '0;
            flush_pending  <= 1'b0;
            parallel_valid <= 1'b0;
            parallel_data  <= '0;
            parallel_count <= '0;
        end else begin
            // Output clears when it drains; a new word loaded below overrides this.
            if (out_free) begin
                parallel_valid <= 1'b0;
                parallel_data  <= '0;
                parallel_count <= '0;
            end
            if (full) begin
                if (out_free) begin
                    parallel_valid <= 1'b1;
                    parallel_data  <= acc;
                    parallel_count <= beats_c;
                    acc            <= nacc;
                    acc_count      <= ncount;
                    flush_pending  <= flush && accept;
                end
            end else if (emit_req && out_free) begin
                parallel_valid <= 1'b1;
                parallel_data  <= nacc;
                parallel_count <= ncount;
                acc            <= '0;
                acc_count      <= '0;
                flush_pending  <= 1'b0;
            end else begin
                acc           <= nacc;
                acc_count     <= ncount;
                flush_pending <= emit_req && !complete;
            end
        end
    end

endmodule
